// File: rtl/multi_key_filter_pkg.sv
// Shared types and helpers for the multi-channel key filter.
// Holds the channel state encoding, the mode codes and the counter sizing function.
package key_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT_REL,
    FIRST,
    REPEAT
  } kf_state_t;

  localparam int KF_MODE_RATE      = 0;
  localparam int KF_MODE_ONESHOT   = 1;
  localparam int KF_MODE_TYPEMATIC = 2;

  // The counter must hold the larger of the two reload values.
  function automatic int kf_cnt_width(input int holdoff, input int repeat_delay);
    int max_cnt;
    max_cnt = (holdoff > repeat_delay) ? holdoff : repeat_delay;
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/multi_key_filter_if.sv
// Key-level bundle between the raw board keys and the control logic.
// The filter itself is the slave: it reads the keys and drives the pulses and levels.
interface multi_key_filter_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] In;
  logic [N_KEYS-1:0] Out;
  logic [N_KEYS-1:0] Held;

  modport slave  (input In, output Out, output Held);
  modport master (output In, input Out, input Held);
endinterface

// File: rtl/multi_key_filter_chan.sv
// One key channel: optional synchronizer, polarity correction, pulse FSM and holdoff counter.
//   state    | meaning
//   IDLE     | ready; the next pressed sample fires a pulse
//   HOLD     | holdoff running, key level ignored until it expires
//   WAIT_REL | one-shot: needs holdoff expired and key released
//   FIRST    | typematic: waiting out the initial repeat delay
//   REPEAT   | typematic: auto-repeating every HOLDOFF cycles
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int HOLDOFF      = 5_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int MODE         = KF_MODE_RATE,
  parameter int SYNC_STAGES  = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Out,
  output logic Held
);

  localparam int CW = kf_cnt_width(HOLDOFF, REPEAT_DELAY);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] DELAY_GAP  = CW'(REPEAT_DELAY - HOLDOFF);

  kf_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_dec;
  logic          raw;
  logic          pressed;

  assign raw     = In ^ (ACTIVE_LOW != 0);
  assign cnt_dec = (cnt == '0) ? '0 : cnt - CW'(1);

  if (SYNC_STAGES == 0) begin : g_nosync
    assign pressed = raw;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[s] <= sync_q[s-1];
        end
      end
    end

    assign pressed = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      Out   <= 1'b0;
      Held  <= 1'b0;
    end else begin
      Out  <= 1'b0;
      Held <= pressed;
      case (state)
        IDLE: begin
          if (pressed) begin
            Out <= 1'b1;
            if (MODE == KF_MODE_TYPEMATIC) begin
              cnt   <= DELAY_LOAD;
              state <= FIRST;
            end else if (MODE == KF_MODE_ONESHOT) begin
              cnt   <= HOLD_LOAD;
              state <= WAIT_REL;
            end else begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end
          end
        end
        // Leave as the count lands on zero so the IDLE re-accept is HOLDOFF after the last pulse.
        HOLD: begin
          cnt <= cnt_dec;
          if (cnt_dec == '0) state <= IDLE;
        end
        WAIT_REL: begin
          cnt <= cnt_dec;
          if (cnt_dec == '0 && !pressed) state <= IDLE;
        end
        FIRST: begin
          if (!pressed) begin
            if (cnt > DELAY_GAP) begin
              cnt   <= cnt - DELAY_GAP;
              state <= HOLD;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end else if (cnt == '0) begin
            Out   <= 1'b1;
            cnt   <= HOLD_LOAD;
            state <= REPEAT;
          end else begin
            cnt <= cnt_dec;
          end
        end
        REPEAT: begin
          if (!pressed) begin
            state <= HOLD;
          end else if (cnt == '0) begin
            Out <= 1'b1;
            cnt <= HOLD_LOAD;
          end else begin
            cnt <= cnt_dec;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_key_filter.sv
// N independent key channels turning raw board keys into single-cycle command pulses.
// No arbitration: simultaneous presses on several channels pulse in the same cycle.
module multi_key_filter
  import key_filter_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int HOLDOFF      = 5_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int MODE         = KF_MODE_RATE,
  parameter int SYNC_STAGES  = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input logic          Clk,
  input logic          Reset,
  multi_key_filter_if.slave kf
);

  if (REPEAT_DELAY < HOLDOFF) begin : g_bad_delay
    $error("multi_key_filter: REPEAT_DELAY must be >= HOLDOFF");
  end
  if (HOLDOFF < 1) begin : g_bad_holdoff
    $error("multi_key_filter: HOLDOFF must be >= 1");
  end

  logic [N_KEYS-1:0] out_w;
  logic [N_KEYS-1:0] held_w;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_filter_chan #(
      .HOLDOFF      (HOLDOFF),
      .REPEAT_DELAY (REPEAT_DELAY),
      .MODE         (MODE),
      .SYNC_STAGES  (SYNC_STAGES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .Clk   (Clk),
      .Reset (Reset),
      .In    (kf.In[i]),
      .Out   (out_w[i]),
      .Held  (held_w[i])
    );
  end

  assign kf.Out  = out_w;
  assign kf.Held = held_w;

endmodule
